// File: rtl/inv_shift_sub_bytes.sv
// inv_shift_sub_bytes
// Iterative InvSubBytes + InvShiftRows stage of the AES inverse round.
// A state is accepted over valid/ready, and LANES output bytes are produced
// per cycle through shared inverse S-box lanes. The finished state is held
// on out_state until the downstream stage takes it.
// Byte k of the state (k = 4c + r) sits at bits [127-8k -: 8].

module inv_shift_sub_bytes #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    // Counter value of the write that covers byte 15, and the per-cycle step.
    // For LANES=16 the step truncates to zero, which is harmless because the
    // first write is already the terminal one.
    localparam logic [3:0] LAST_CNT = 4'(16 - LANES);
    localparam logic [3:0] STEP     = 4'(LANES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // FIPS-197 inverse S-box.
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // One inverse S-box lookup; each lane instantiates its own copy.
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

    // Source byte for output byte k under InvShiftRows: row r is rotated
    // right by r, so output (r, c) comes from input (r, (c - r) mod 4).
    // The 2-bit subtraction provides the mod 4 wrap.
    function automatic logic [7:0] shifted_src(input logic [127:0] cap, input logic [3:0] k);
        logic [1:0] src_col;
        logic [3:0] idx;
        src_col = k[3:2] - k[1:0];
        idx     = {src_col, k[1:0]};
        return cap[127 - 8 * int'(idx) -: 8];
    endfunction

    state_e         state_q, state_d;
    logic [127:0]   cap_q, cap_d;
    logic [127:0]   out_q, out_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           out_valid_q, out_valid_d;
    logic           in_ready_q, in_ready_d;
    logic           busy_q, busy_d;

    // Next-state, capture, byte-write and registered-output decode.
    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    cap_d   = in_state;
                    cnt_d   = 4'd0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                for (int l = 0; l < LANES; l++) begin
                    out_d[127 - 8 * int'(cnt_q + 4'(l)) -: 8] =
                        inv_sbox(shifted_src(cap_q, cnt_q + 4'(l)));
                end
                cnt_d = cnt_q + STEP;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        out_valid_d = (state_d == S_DONE);
        in_ready_d  = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    // State, datapath and handshake registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cap_q       <= 128'd0;
            out_q       <= 128'd0;
            cnt_q       <= 4'd0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cap_q       <= cap_d;
            out_q       <= out_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_state = out_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_inv_shift_sub_bytes.sv
// Self-checking bench for inv_shift_sub_bytes (LANES=4 main instance,
// LANES=1 second instance for the slow-lane latency case).
// The reference inverse S-box is derived from GF(2^8) arithmetic.

module tb_inv_shift_sub_bytes;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] in_state, out_state;
    logic         in_valid1, in_ready1, out_valid1, out_ready1, busy1;
    logic [127:0] in_state1, out_state1;

    int errors = 0;
    int checks = 0;
    logic [7:0] isbox [256];

    always #5 clk = ~clk;

    inv_shift_sub_bytes #(.LANES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
        .busy(busy)
    );

    inv_shift_sub_bytes #(.LANES(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_state(in_state1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_state(out_state1),
        .busy(busy1)
    );

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic       hi;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b  = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    // Forward S-box: multiplicative inverse (x^254) followed by the affine map.
    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] v = 8'h01;
        logic [7:0] s;
        if (x == 8'h00) v = 8'h00;
        else for (int i = 0; i < 254; i++) v = gmul(v, x);
        s = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
        return s;
    endfunction

    // Reference: arrange as a 4x4 matrix, invert each byte, rotate row r right by r.
    function automatic logic [127:0] ref_out(input logic [127:0] s);
        logic [7:0]   m [4][4];
        logic [7:0]   t [4][4];
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                m[r][c] = s[127 - 8 * (4 * c + r) -: 8];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[r][(c + r) % 4] = isbox[m[r][c]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8 * (4 * c + r) -: 8] = t[r][c];
        return o;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for in_ready, then present one state for one cycle.
    task automatic send(input logic [127:0] d);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_seen", 128'(in_ready), 128'd1);
        in_valid = 1'b1;
        in_state = d;
        @(negedge clk);
        in_valid = 1'b0;
        in_state = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Count cycles from the accept edge until out_valid; optionally toggle out_ready randomly.
    task automatic wait_valid(input bit rnd_ready, output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] t2_in, t2_exp, exp, held, d;
        int cyc;

        for (int x = 0; x < 256; x++) isbox[fwd_sbox(8'(x))] = 8'(x);
        check("model_00", 128'(isbox[8'h00]), 128'h52);
        check("model_63", 128'(isbox[8'h63]), 128'h00);
        check("model_7c", 128'(isbox[8'h7c]), 128'h01);
        check("model_ff", 128'(isbox[8'hff]), 128'h7d);

        rst_n = 1'b0;
        in_valid = 1'b0; in_state = 128'd0; out_ready = 1'b0;
        in_valid1 = 1'b0; in_state1 = 128'd0; out_ready1 = 1'b0;
        #2;
        check("rst_out_state", out_state, 128'd0);
        check("rst_flags", 128'({in_ready, out_valid, busy}), 128'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); @(negedge clk);

        // T1: zero state, out_ready held high.
        out_ready = 1'b1;
        send(128'd0);
        wait_valid(1'b0, cyc);
        check("t1_latency", 128'(cyc), 128'd4);
        check("t1_out_state", out_state, {16{8'h52}});
        check("t1_busy", 128'(busy), 128'd1);
        @(negedge clk);
        check("t1_taken", 128'({out_valid, busy, in_ready}), 128'b001);
        out_ready = 1'b0;

        // T2/T3: reference vector, then a 10-cycle stall with a stray in_valid pulse.
        t2_in  = 128'h637c777bf26b6fc53001672bfed7ab76;
        t2_exp = 128'h000d0a07_04010e0b_0805020f_0c090603;
        send(t2_in);
        wait_valid(1'b0, cyc);
        check("t2_latency", 128'(cyc), 128'd4);
        check("t2_out_state", out_state, t2_exp);
        check("t2_model", ref_out(t2_in), t2_exp);
        held = out_state;
        for (int i = 0; i < 10; i++) begin
            in_valid = (i == 3);
            in_state = {4{32'hdeadbeef}};
            @(negedge clk);
            check("t3_hold_state", out_state, held);
            check("t3_hold_flags", 128'({out_valid, in_ready, busy}), 128'b101);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("t3_taken", 128'({out_valid, busy}), 128'b00);
        @(negedge clk);
        check("t3_pulse_ignored", 128'({busy, in_ready}), 128'b01);

        // T4: asynchronous reset in the middle of RUN.
        send({$urandom, $urandom, $urandom, $urandom});
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t4_rst_state", out_state, 128'd0);
        check("t4_rst_flags", 128'({in_ready, out_valid, busy}), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send({16{8'h63}});
        wait_valid(1'b0, cyc);
        check("t4_latency", 128'(cyc), 128'd4);
        check("t4_out_state", out_state, 128'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // T5: single-lane instance, 16-cycle latency.
        cyc = 0;
        while (!in_ready1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        in_valid1 = 1'b1;
        in_state1 = t2_in;
        @(negedge clk);
        in_valid1 = 1'b0;
        cyc = 0;
        while (!out_valid1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("t5_latency", 128'(cyc), 128'd16);
        check("t5_out_state", out_state1, t2_exp);
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;
        check("t5_taken", 128'(out_valid1), 128'd0);

        // T6: 100 random states back to back with random out_ready.
        for (int n = 0; n < 100; n++) begin
            d   = {$urandom, $urandom, $urandom, $urandom};
            exp = ref_out(d);
            send(d);
            wait_valid(1'b1, cyc);
            check("t6_latency", 128'(cyc), 128'd4);
            check("t6_out_state", out_state, exp);
            repeat ($urandom_range(0, 3)) begin
                out_ready = 1'b0;
                @(negedge clk);
                check("t6_stall", {out_state[127:2], out_valid, in_ready}, {exp[127:2], 2'b10});
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check("t6_taken", 128'({out_valid, in_ready}), 128'b01);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
